plic_mc_core: RTL and testbench
===============================

PLIC_MC_CORE -- requirements
Module: plic_mc_core

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 31: interrupt source count, legal 1..31; source IDs are 1..NUM_SRC, ID 0 means "none".
REQ-002 SHALL provide parameter NUM_TGT, default 2: interrupt target (context) count, legal 1..8.
REQ-003 SHALL provide parameter PRIO_W, default 3: priority and threshold width, legal 1..8.
REQ-004 SHALL provide parameter ADDR_W, default 16: AXI4-Lite address width, legal 15..32.
REQ-005 SHALL have port clk_i, input, 1: sole clock; one clock; all logic on the rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset; synchronous and active-high.
REQ-007 SHALL have port intr_src_i, input, NUM_SRC: bit k is source ID k+1; synchronous to clk_i.
REQ-008 SHALL have port irq_o, output, NUM_TGT: per-target interrupt request, registered.
REQ-009 SHALL have port irq_id_o, output, NUM_TGT*5: per-target best pending ID, registered.
REQ-010 SHALL have ports s_axi_aw{addr,valid,ready}, w{data,strb,valid,ready}, b{resp,valid,ready}, ar{addr,valid,ready}, r{data,resp,valid,ready}: AXI4-Lite slave, 32-bit data, ADDR_W-bit address.

Function
REQ-011 Register map (word aligned, addr[1:0] ignored):
- 0x0000+4*id: PRIO[id], RW, PRIO_W bits.
- 0x1000: PENDING, RO, bit id.
- 0x1004: EDGE, RW, bit id; 1 = edge mode, 0 = level mode.
- 0x2000+0x80*t: ENABLE[t], RW, bit id.
- 0x4000+0x100*t: THRESH[t], RW, PRIO_W bits.
- 0x4004+0x100*t: CLAIM/COMPLETE[t].
REQ-012 Unmapped addresses, bit 0 of every register, and bits above NUM_SRC SHALL read zero; writes to them SHALL be ignored; bresp and rresp SHALL always be OKAY (2'b00).
REQ-013 Writes SHALL honour wstrb per byte.
REQ-014 AXI FSM states and transitions:
- IDLE -> WRESP: when awvalid && wvalid, assert awready and wready for 1 cycle, perform the write.
- WRESP: bvalid=1 until bready, then -> IDLE.
- IDLE -> RRESP: when arvalid and no write is pending; assert arready for 1 cycle.
- RRESP: rvalid=1, rdata stable until rready, then -> IDLE.
REQ-015 If a write and a read are both ready in IDLE, the write SHALL win. Only one transaction SHALL be outstanding at any time.
REQ-016 Level gateway: when source high, pending=0 and in_flight=0, set pending on the next cycle.
REQ-017 Edge gateway: a rising edge (registered previous sample) SHALL increment a 2-bit per-source counter, saturating at 3. When counter>0, pending=0 and in_flight=0, set pending and decrement the counter. An increment and a decrement in the same cycle SHALL leave the counter unchanged.
REQ-018 Writing EDGE SHALL clear that source's edge counter.
REQ-019 A source is eligible for target t when pending && ENABLE[t][id] && PRIO[id] > THRESH[t]. PRIO 0 SHALL never interrupt.
REQ-020 Per target, the best ID is the eligible source with the highest PRIO; ties go to the lowest ID; result is 0 if none are eligible.
REQ-021 irq_id_o[t] SHALL register the best ID each cycle, and irq_o[t] = (irq_id_o[t] != 0). Latency from a register/pending change to irq_o is 1 cycle.
REQ-022 Claim: a read of CLAIM[t] SHALL return the registered irq_id_o[t] sampled at ar handshake. If it is nonzero, the same cycle SHALL clear pending[id] and set in_flight[id]. A claim with no eligible source returns 0 with no side effects.
REQ-023 Complete: a write of id to COMPLETE[t] SHALL clear in_flight[id] only if 1<=id<=NUM_SRC and in_flight[id]=1; otherwise it is ignored. Enable state SHALL NOT gate completion.
REQ-024 Simultaneous claim-clear and gateway-set of the same pending bit SHALL resolve as clear; the gateway re-evaluates the next cycle.
REQ-025 Clearing ENABLE or raising THRESH SHALL deassert irq_o within 1 cycle and leave pending unchanged.

Reset
REQ-026 On rst_i=1 at a clock edge, SHALL zero all PRIO, ENABLE, THRESH, EDGE, pending, in_flight, edge counters and edge-detect registers.
REQ-027 On reset, SHALL return the AXI FSM to IDLE and drive all ready/valid outputs 0, irq_o=0 and irq_id_o=0 in the cycle after reset is sampled.
REQ-028 Reset asserted mid-transaction SHALL abort it without issuing a response.

Verification
REQ-029 Level: PRIO[3]=2, ENABLE[0]=0x8, THRESH[0]=0, raise src3 -> irq_o[0]=1, irq_id 3 in 2 cycles; claim returns 3, irq_o[0]=0; with src held, no reassert until complete(3), then reasserts within 2 cycles.
REQ-030 Arbitration: src2 PRIO=5, src5 PRIO=5, src7 PRIO=6, all enabled -> claims return 7, 2, 5, then 0.
REQ-031 Edge: EDGE[4]=1, four pulses on src4 while in_flight -> after each complete, claims return 4 exactly 3 more times (counter saturates at 3), then 0.
REQ-032 Threshold/targets: PRIO[1]=3, THRESH[0]=3, THRESH[1]=2, both enabled -> irq_o=2'b10; complete(9) with NUM_SRC=8 ignored.
REQ-033 AXI: awvalid, wvalid and arvalid asserted in the same cycle -> write handled first; hold bready=0 for 5 cycles -> bvalid held; wstrb=4'b0001 on ENABLE -> only bits 7:0 updated.
REQ-034 Reset: assert rst_i during RRESP -> rvalid=0 next cycle; all registers read 0 afterwards.

Source files
------------

// File: rtl/plic_mc_core.sv
// Platform-level interrupt controller core.
// Level/edge gateways per source, per-target priority arbitration, and an
// AXI4-Lite register slave that handles one transaction at a time, with writes
// taking precedence over reads.
module plic_mc_core #(
    parameter int NUM_SRC = 31,
    parameter int NUM_TGT = 2,
    parameter int PRIO_W  = 3,
    parameter int ADDR_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_SRC-1:0]   intr_src_i,
    output logic [NUM_TGT-1:0]   irq_o,
    output logic [NUM_TGT*5-1:0] irq_id_o,
    input  logic [ADDR_W-1:0]    s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready
);
    localparam logic [2:0] K_NONE = 3'd0, K_PRIO = 3'd1, K_PEND = 3'd2, K_EDGE = 3'd3,
                           K_EN = 3'd4, K_TH = 3'd5, K_CLAIM = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_WRESP, S_RRESP} state_t;

    // Address decode: returns {kind, index}; index is the source ID or target number.
    function automatic logic [7:0] f_dec(input logic [31:0] a);
        logic [7:0] d;
        d = {K_NONE, 5'd0};
        if (a[31:15] == 17'd0) begin
            if (a[14:7] == 8'd0) begin
                if (a[6:2] != 5'd0 && {27'd0, a[6:2]} <= 32'(NUM_SRC)) d = {K_PRIO, a[6:2]};
            end else if (a[14:2] == 13'h0400) begin
                d = {K_PEND, 5'd0};
            end else if (a[14:2] == 13'h0401) begin
                d = {K_EDGE, 5'd0};
            end else if (a[14:10] == 5'b01000 && a[6:2] == 5'd0) begin
                if ({29'd0, a[9:7]} < 32'(NUM_TGT)) d = {K_EN, 2'b00, a[9:7]};
            end else if (a[14:11] == 4'b1000 && {29'd0, a[10:8]} < 32'(NUM_TGT)) begin
                if (a[7:2] == 6'd0)      d = {K_TH, 2'b00, a[10:8]};
                else if (a[7:2] == 6'd1) d = {K_CLAIM, 2'b00, a[10:8]};
            end
        end
        return d;
    endfunction

    // Byte-lane merge of write data into an existing 32-bit register image.
    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
        return (old & ~m) | (data & m);
    endfunction

    state_t              r_state, w_state_next;
    logic                w_wr_go, w_rd_go;
    logic [PRIO_W-1:0]   r_prio [NUM_SRC];
    logic [NUM_SRC-1:0]  r_enable [NUM_TGT];
    logic [PRIO_W-1:0]   r_thresh [NUM_TGT];
    logic [NUM_SRC-1:0]  r_edge, r_pending, r_in_flight, r_prev;
    logic [1:0]          r_cnt [NUM_SRC];
    logic [1:0]          w_cnt_next [NUM_SRC];
    logic [NUM_SRC-1:0]  w_pend_next, w_infl_next, w_claim_vec, w_complete_vec, w_edge_clr;
    logic [4:0]          r_irq_id [NUM_TGT];
    logic [4:0]          w_best_id [NUM_TGT];
    logic [NUM_TGT-1:0]  r_irq;
    logic [31:0]         r_rdata, w_rdata, w_wval;
    logic [7:0]          w_wdec, w_rdec;
    logic [2:0]          w_wkind, w_rkind;
    logic [4:0]          w_widx, w_ridx, w_claim_id;

    assign w_wdec  = f_dec(32'(s_axi_awaddr));
    assign w_rdec  = f_dec(32'(s_axi_araddr));
    assign w_wkind = w_wdec[7:5];
    assign w_widx  = w_wdec[4:0];
    assign w_rkind = w_rdec[7:5];
    assign w_ridx  = w_rdec[4:0];
    assign w_wval  = f_merge(32'd0, s_axi_wdata, s_axi_wstrb);

    // Bus FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Bus FSM next state and handshake strobes; a complete write beats a read.
    always_comb begin
        w_state_next = r_state;
        w_wr_go      = 1'b0;
        w_rd_go      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_wr_go      = 1'b1;
                    w_state_next = S_WRESP;
                end else if (s_axi_arvalid) begin
                    w_rd_go      = 1'b1;
                    w_state_next = S_RRESP;
                end
            end
            S_WRESP: if (s_axi_bready) w_state_next = S_IDLE;
            S_RRESP: if (s_axi_rready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (rst_i) begin
            w_wr_go = 1'b0;
            w_rd_go = 1'b0;
        end
    end

    assign s_axi_awready = w_wr_go;
    assign s_axi_wready  = w_wr_go;
    assign s_axi_arready = w_rd_go;
    assign s_axi_bvalid  = (r_state == S_WRESP);
    assign s_axi_rvalid  = (r_state == S_RRESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = r_rdata;
    assign irq_o         = r_irq;

    // Read data mux plus the ID a claim read would take from its target.
    always_comb begin
        w_rdata    = 32'd0;
        w_claim_id = 5'd0;
        for (int k = 0; k < NUM_SRC; k++)
            if (w_rkind == K_PRIO && w_ridx == 5'(k + 1)) w_rdata[PRIO_W-1:0] = r_prio[k];
        if (w_rkind == K_PEND) w_rdata[NUM_SRC:1] = r_pending;
        if (w_rkind == K_EDGE) w_rdata[NUM_SRC:1] = r_edge;
        for (int t = 0; t < NUM_TGT; t++) begin
            if (w_ridx == 5'(t)) begin
                if (w_rkind == K_EN)    w_rdata[NUM_SRC:1]  = r_enable[t];
                if (w_rkind == K_TH)    w_rdata[PRIO_W-1:0] = r_thresh[t];
                if (w_rkind == K_CLAIM) begin
                    w_rdata[4:0] = r_irq_id[t];
                    w_claim_id   = r_irq_id[t];
                end
            end
        end
    end

    // Read data is captured at the address handshake and held until rready.
    always_ff @(posedge clk_i) begin
        if (rst_i)        r_rdata <= 32'd0;
        else if (w_rd_go) r_rdata <= w_rdata;
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_SRC; k++) r_prio[k] <= '0;
            for (int t = 0; t < NUM_TGT; t++) begin
                r_enable[t] <= '0;
                r_thresh[t] <= '0;
            end
            r_edge <= '0;
        end else if (w_wr_go) begin
            for (int k = 0; k < NUM_SRC; k++)
                if (w_wkind == K_PRIO && w_widx == 5'(k + 1))
                    r_prio[k] <= PRIO_W'(f_merge(32'(r_prio[k]), s_axi_wdata, s_axi_wstrb));
            if (w_wkind == K_EDGE)
                r_edge <= NUM_SRC'(f_merge(32'({r_edge, 1'b0}), s_axi_wdata, s_axi_wstrb) >> 1);
            for (int t = 0; t < NUM_TGT; t++) begin
                if (w_wkind == K_EN && w_widx == 5'(t))
                    r_enable[t] <= NUM_SRC'(f_merge(32'({r_enable[t], 1'b0}), s_axi_wdata,
                                                    s_axi_wstrb) >> 1);
                if (w_wkind == K_TH && w_widx == 5'(t))
                    r_thresh[t] <= PRIO_W'(f_merge(32'(r_thresh[t]), s_axi_wdata, s_axi_wstrb));
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic w_idle, w_inc, w_dec, w_set;
            assign w_claim_vec[gi]    = w_rd_go && (w_rkind == K_CLAIM) && (w_claim_id == 5'(gi + 1));
            assign w_complete_vec[gi] = w_wr_go && (w_wkind == K_CLAIM) && (w_wval == 32'(gi + 1));
            assign w_edge_clr[gi]     = w_wr_go && (w_wkind == K_EDGE) && s_axi_wstrb[(gi + 1) / 8];
            assign w_idle = !r_pending[gi] && !r_in_flight[gi];
            assign w_inc  = r_edge[gi] && intr_src_i[gi] && !r_prev[gi];
            // A claim hitting this source wins, so the counter is left for later.
            assign w_dec  = r_edge[gi] && (r_cnt[gi] != 2'd0) && w_idle && !w_claim_vec[gi];
            assign w_set  = r_edge[gi] ? w_dec : (intr_src_i[gi] && w_idle);
            assign w_pend_next[gi] = w_claim_vec[gi] ? 1'b0 : (w_set ? 1'b1 : r_pending[gi]);
            assign w_infl_next[gi] = w_claim_vec[gi] ? 1'b1 :
                                     (w_complete_vec[gi] ? 1'b0 : r_in_flight[gi]);
            assign w_cnt_next[gi]  = w_edge_clr[gi]     ? 2'd0 :
                                     (w_inc && !w_dec)  ? ((r_cnt[gi] == 2'd3) ? 2'd3 : r_cnt[gi] + 2'd1) :
                                     (w_dec && !w_inc)  ? r_cnt[gi] - 2'd1 : r_cnt[gi];
        end

        for (gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
            logic [4:0]        w_id;
            logic [PRIO_W-1:0] w_p;
            // Highest priority wins; strict compare in ascending ID order keeps ties on the lowest ID.
            always_comb begin
                w_id = 5'd0;
                w_p  = '0;
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (r_pending[k] && r_enable[gi][k] && (r_prio[k] > r_thresh[gi]) && (r_prio[k] > w_p)) begin
                        w_id = 5'(k + 1);
                        w_p  = r_prio[k];
                    end
                end
            end
            assign w_best_id[gi]        = w_id;
            assign irq_id_o[5*gi +: 5]  = r_irq_id[gi];
        end
    endgenerate

    // Gateway state: pending, in-flight, edge counters and edge-detect samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending   <= '0;
            r_in_flight <= '0;
            r_prev      <= '0;
            for (int k = 0; k < NUM_SRC; k++) r_cnt[k] <= 2'd0;
        end else begin
            r_pending   <= w_pend_next;
            r_in_flight <= w_infl_next;
            r_prev      <= intr_src_i;
            for (int k = 0; k < NUM_SRC; k++) r_cnt[k] <= w_cnt_next[k];
        end
    end

    // Registered per-target best ID and request.
    always_ff @(posedge clk_i) begin
        for (int t = 0; t < NUM_TGT; t++) begin
            if (rst_i) begin
                r_irq_id[t] <= 5'd0;
                r_irq[t]    <= 1'b0;
            end else begin
                r_irq_id[t] <= w_best_id[t];
                r_irq[t]    <= (w_best_id[t] != 5'd0);
            end
        end
    end
endmodule

// File: tb/tb_plic_mc_core.sv
// Bench for plic_mc_core: directed scenarios plus a randomized phase checked
// against a transaction-level model of pending/in-flight/arbitration rules.
module tb_plic_mc_core;
    localparam int NS = 8, NT = 2, PW = 3, AW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    src;
    logic [NT-1:0]    irq;
    logic [NT*5-1:0]  irq_id;
    logic [AW-1:0]    awaddr, araddr;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [31:0]      wdata, rdata;
    logic [3:0]       wstrb;
    logic [1:0]       bresp, rresp;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (IDs 1..NS; index 0 unused)
    int          m_prio [NS+1];
    bit          m_src  [NS+1];
    bit          m_infl [NS+1];
    logic [31:0] m_en   [NT];
    int          m_th   [NT];

    plic_mc_core #(.NUM_SRC(NS), .NUM_TGT(NT), .PRIO_W(PW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .intr_src_i(src), .irq_o(irq), .irq_id_o(irq_id),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        bit ok;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            #1;
            if (awready && wready) ok = 1'b1;
            else begin @(negedge clk); n++; end
        end
        check("aw_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
        int n;
        bit ok;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            #1;
            if (arready) ok = 1'b1;
            else begin @(negedge clk); n++; end
        end
        check("ar_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        check("rvalid", 32'(rvalid), 32'd1);
        d = rdata;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; src = '0;
        @(posedge clk); #1;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_irq_id", 32'(irq_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input int bitpos);
        @(negedge clk); src[bitpos] = 1'b1;
        @(negedge clk); src[bitpos] = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Best eligible ID for target t: highest priority above threshold, lowest ID on ties.
    function automatic int model_best(input int t);
        int best, bp;
        best = 0; bp = 0;
        for (int id = 1; id <= NS; id++)
            if (m_src[id] && !m_infl[id] && m_en[t][id] && m_prio[id] > m_th[t] && m_prio[id] > bp) begin
                best = id;
                bp   = m_prio[id];
            end
        return best;
    endfunction

    initial begin
        logic [31:0] rd;
        int          seq [4];
        rst = 1'b1; src = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_irq_id", 32'(irq_id), 32'd0);
        check("reset_bvalid", 32'(bvalid), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Level source: assert, claim, hold off until complete
        axi_write(16'h000C, 32'd2, 4'hF);
        axi_write(16'h2000, 32'h8, 4'hF);
        axi_write(16'h4000, 32'd0, 4'hF);
        @(negedge clk); src[2] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("lvl_irq", 32'(irq[0]), 32'd1);
        check("lvl_id", 32'(irq_id[4:0]), 32'd3);
        axi_read(16'h4004, rd);
        check("lvl_claim", rd, 32'd3);
        check("lvl_irq_after_claim", 32'(irq[0]), 32'd0);
        settle(4);
        check("lvl_no_reassert", 32'(irq[0]), 32'd0);
        axi_write(16'h4004, 32'd3, 4'hF);
        settle(1);
        check("lvl_reassert", 32'(irq[0]), 32'd1);

        // Arbitration: priority first, then lowest ID
        do_reset();
        axi_write(16'h0008, 32'd5, 4'hF);
        axi_write(16'h0014, 32'd5, 4'hF);
        axi_write(16'h001C, 32'd6, 4'hF);
        axi_write(16'h2000, 32'hA4, 4'hF);
        @(negedge clk); src = 8'b0101_0010;
        settle(3);
        seq = '{7, 2, 5, 0};
        for (int i = 0; i < 4; i++) begin
            axi_read(16'h4004, rd);
            check("arb_claim", rd, 32'(seq[i]));
            settle(2);
        end

        // Edge mode: counter saturates at three queued edges
        do_reset();
        axi_write(16'h1004, 32'h10, 4'hF);
        axi_write(16'h0010, 32'd1, 4'hF);
        axi_write(16'h2000, 32'h10, 4'hF);
        pulse(3);
        settle(2);
        axi_read(16'h4004, rd);
        check("edge_first_claim", rd, 32'd4);
        for (int i = 0; i < 4; i++) pulse(3);
        for (int i = 0; i < 4; i++) begin
            axi_write(16'h4004, 32'd4, 4'hF);
            settle(3);
            axi_read(16'h4004, rd);
            check("edge_claim", rd, (i < 3) ? 32'd4 : 32'd0);
        end

        // Thresholds per target; out-of-range completion ignored
        do_reset();
        axi_write(16'h0004, 32'd3, 4'hF);
        axi_write(16'h4000, 32'd3, 4'hF);
        axi_write(16'h4100, 32'd2, 4'hF);
        axi_write(16'h2000, 32'h2, 4'hF);
        axi_write(16'h2080, 32'h2, 4'hF);
        @(negedge clk); src[0] = 1'b1;
        settle(3);
        check("thr_irq", 32'(irq), 32'b10);
        check("thr_id1", 32'(irq_id[9:5]), 32'd1);
        axi_read(16'h4104, rd);
        check("thr_claim", rd, 32'd1);
        axi_write(16'h4104, 32'd9, 4'hF);
        settle(3);
        check("complete9_ignored", 32'(irq), 32'd0);
        axi_write(16'h4104, 32'd1, 4'hF);
        settle(3);
        check("complete1_irq", 32'(irq), 32'b10);
        axi_write(16'h0024, 32'd7, 4'hF);
        axi_read(16'h0024, rd);
        check("unmapped_prio9", rd, 32'd0);

        // Write wins over read; bvalid holds; byte strobes honoured
        do_reset();
        axi_write(16'h2000, 32'hFFFF_FFFF, 4'hF);
        axi_read(16'h2000, rd);
        check("en_full", rd, 32'h1FE);
        @(negedge clk);
        bready = 1'b0;
        awaddr = 16'h2000; wdata = 32'h0; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'h2000; arvalid = 1'b1;
        #1;
        check("write_first_aw", 32'(awready), 32'd1);
        check("write_first_ar", 32'(arready), 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("ar_blocked", 32'(arready), 32'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("ar_after_b", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("strb_rvalid", 32'(rvalid), 32'd1);
        check("strb_rdata", rdata, 32'h100);
        @(posedge clk); #1;

        // Reset during a read response
        axi_write(16'h0004, 32'd7, 4'hF);
        axi_write(16'h1004, 32'h1FE, 4'hF);
        axi_write(16'h2080, 32'h6, 4'hF);
        axi_write(16'h4100, 32'd5, 4'hF);
        @(negedge clk);
        rready = 1'b0; araddr = 16'h0004; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rresp_rvalid", 32'(rvalid), 32'd1);
        check("rresp_rdata", rdata, 32'd7);
        @(posedge clk); #1;
        check("rdata_stable", rdata, 32'd7);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_abort_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk); rst = 1'b0; rready = 1'b1;
        axi_read(16'h0004, rd); check("post_rst_prio1", rd, 32'd0);
        axi_read(16'h1004, rd); check("post_rst_edge", rd, 32'd0);
        axi_read(16'h2080, rd); check("post_rst_en1", rd, 32'd0);
        axi_read(16'h4100, rd); check("post_rst_th1", rd, 32'd0);
        axi_read(16'h1000, rd); check("post_rst_pend", rd, 32'd0);

        // Randomized phase against the reference model (level sources held static)
        do_reset();
        for (int id = 0; id <= NS; id++) begin
            m_prio[id] = 0; m_infl[id] = 1'b0; m_src[id] = 1'b0;
        end
        for (int t = 0; t < NT; t++) begin m_en[t] = 32'd0; m_th[t] = 0; end
        @(negedge clk);
        src = 8'($urandom);
        for (int id = 1; id <= NS; id++) m_src[id] = src[id-1];
        for (int it = 0; it < 80; it++) begin
            int          op, t, id, e;
            logic [31:0] d;
            op = $urandom_range(0, 4);
            t  = $urandom_range(0, NT - 1);
            d  = $urandom;
            case (op)
                0: begin
                    e = model_best(t);
                    axi_read(16'h4004 + 16'(t * 256), rd);
                    check("rnd_claim", rd, 32'(e));
                    if (e != 0) m_infl[e] = 1'b1;
                end
                1: begin
                    id = $urandom_range(0, 10);
                    axi_write(16'h4004 + 16'(t * 256), 32'(id), 4'hF);
                    if (id >= 1 && id <= NS) m_infl[id] = 1'b0;
                end
                2: begin
                    id = $urandom_range(1, NS);
                    axi_write(16'(4 * id), d, 4'hF);
                    m_prio[id] = int'(d & 32'd7);
                end
                3: begin
                    axi_write(16'h2000 + 16'(t * 128), d, 4'hF);
                    m_en[t] = d & 32'h1FE;
                end
                default: begin
                    axi_write(16'h4000 + 16'(t * 256), d, 4'hF);
                    m_th[t] = int'(d & 32'd7);
                end
            endcase
            settle(3);
            for (int k = 0; k < NT; k++) begin
                check("rnd_irq_id", 32'(irq_id[5*k +: 5]), 32'(model_best(k)));
                check("rnd_irq", 32'(irq[k]), 32'(model_best(k) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
